// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared state enum, opcode set, width defaults and lane slice helper
// No ports: imported by pixel_alu, pixel_processor_array.
package pixel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int INSTRUCTION_WIDTH_DEFAULT = 49;
    localparam int PIXEL_WIDTH_DEFAULT       = 12;

    // Microcode word layout: [2:0] opcode, [3 +: PIXEL_WIDTH] immediate, rest reserved.
    localparam int OP_WIDTH = 3;
    localparam int IMM_LSB  = OP_WIDTH;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_LOAD    = 3'd1,
        OP_ADD_IMM = 3'd2,
        OP_ADD_X   = 3'd3,
        OP_ADD_Y   = 3'd4,
        OP_ADD_F   = 3'd5,
        OP_XOR_IMM = 3'd6,
        OP_SHL     = 3'd7
    } op_t;

    // Bit offset of lane `lane` inside the packed result bus.
    function automatic int lane_lsb(input int lane, input int pixel_width);
        return lane * pixel_width;
    endfunction

endpackage

// File: rtl/pixel_alu.sv
// rtl/pixel_alu.sv - one accumulator lane executing one microcode word per cycle
// Ports: clk, reset; instruction word; x/y/f lane coordinates; result = accumulator after this word.
module pixel_alu
    import pixel_pkg::*;
#(
    parameter int INSTRUCTION_WIDTH = INSTRUCTION_WIDTH_DEFAULT,
    parameter int PIXEL_WIDTH       = PIXEL_WIDTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction,
    input  logic [31:0]                  x,
    input  logic [31:0]                  y,
    input  logic [31:0]                  f,
    output logic [PIXEL_WIDTH-1:0]       result
);

    logic [PIXEL_WIDTH-1:0] acc;
    logic [PIXEL_WIDTH-1:0] acc_next;
    logic [PIXEL_WIDTH-1:0] imm;
    op_t                    op;
    logic                   unused_bits;

    assign op  = op_t'(instruction[OP_WIDTH-1:0]);
    assign imm = instruction[IMM_LSB +: PIXEL_WIDTH];
    assign unused_bits = ^{instruction[INSTRUCTION_WIDTH-1:IMM_LSB+PIXEL_WIDTH],
                           x[31:PIXEL_WIDTH], y[31:PIXEL_WIDTH], f[31:PIXEL_WIDTH]};

    always_comb begin
        acc_next = acc;
        case (op)
            OP_NOP:     acc_next = acc;
            OP_LOAD:    acc_next = imm;
            OP_ADD_IMM: acc_next = acc + imm;
            OP_ADD_X:   acc_next = acc + x[PIXEL_WIDTH-1:0];
            OP_ADD_Y:   acc_next = acc + y[PIXEL_WIDTH-1:0];
            OP_ADD_F:   acc_next = acc + f[PIXEL_WIDTH-1:0];
            OP_XOR_IMM: acc_next = acc ^ imm;
            OP_SHL:     acc_next = {acc[PIXEL_WIDTH-2:0], 1'b0};
            default:    acc_next = acc;
        endcase
    end

    // Result includes the word currently presented, so while the last slot is
    // re-applied in DONE an idempotent word keeps the output steady.
    assign result = acc_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/pixel_scan_counter.sv
// rtl/pixel_scan_counter.sv - batch coordinate and frame counter with end-of-line/last-batch flags
// Ports: clk, reset; restart (new frame), advance (batch accepted); batch_x, batch_y, frame_number; end_of_line, last_batch.
module pixel_scan_counter #(
    parameter int NUM_PIXELS    = 8,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic        advance,
    output logic [31:0] batch_x,
    output logic [31:0] batch_y,
    output logic [31:0] frame_number,
    output logic        end_of_line,
    output logic        last_batch
);

    assign end_of_line = (batch_x == 32'(SCREEN_WIDTH - NUM_PIXELS));
    assign last_batch  = end_of_line && (batch_y == 32'(SCREEN_HEIGHT - 1));

    // Restart wins over advance; the final batch leaves coordinates in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            batch_x      <= '0;
            batch_y      <= '0;
            frame_number <= '0;
        end else if (restart) begin
            batch_x      <= '0;
            batch_y      <= '0;
            frame_number <= frame_number + 32'd1;
        end else if (advance && !last_batch) begin
            if (end_of_line) begin
                batch_x <= '0;
                batch_y <= batch_y + 32'd1;
            end else begin
                batch_x <= batch_x + 32'(NUM_PIXELS);
            end
        end
    end

endmodule

// File: rtl/sram_1r1w.sv
// rtl/sram_1r1w.sv - single-clock memory, one write port, one registered read port
// Ports: clk; wr_en/wr_addr/wr_data write; rd_addr in, rd_data out one cycle later.
module sram_1r1w #(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = 49,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read returns the old word on a same-address write; new data is seen next cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/pixel_processor_array.sv
// rtl/pixel_processor_array.sv - microcoded lane array sequenced batch by batch over a frame
// Ports: clk, reset, new_frame; ucode_wr_en/addr/data microcode write; result/result_valid/result_ready batch handshake;
//        batch_x, batch_y, frame_number coordinates; frame_done pulse; busy.
module pixel_processor_array
    import pixel_pkg::*;
#(
    parameter int NUM_PIXELS        = 8,
    parameter int SCREEN_WIDTH      = 640,
    parameter int SCREEN_HEIGHT     = 480,
    parameter int UCODE_DEPTH       = 16,
    parameter int INSTRUCTION_WIDTH = INSTRUCTION_WIDTH_DEFAULT,
    parameter int PIXEL_WIDTH       = PIXEL_WIDTH_DEFAULT
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              new_frame,
    input  logic                              ucode_wr_en,
    input  logic [$clog2(UCODE_DEPTH)-1:0]    ucode_wr_addr,
    input  logic [INSTRUCTION_WIDTH-1:0]      ucode_wr_data,
    output logic [NUM_PIXELS*PIXEL_WIDTH-1:0] result,
    output logic                              result_valid,
    input  logic                              result_ready,
    output logic [31:0]                       batch_x,
    output logic [31:0]                       batch_y,
    output logic [31:0]                       frame_number,
    output logic                              frame_done,
    output logic                              busy
);

    localparam int ADDR_WIDTH = $clog2(UCODE_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(UCODE_DEPTH - 1);

    if (SCREEN_WIDTH % NUM_PIXELS != 0) begin : g_bad_width
        $error("SCREEN_WIDTH must be a multiple of NUM_PIXELS");
    end
    if (UCODE_DEPTH < 2 || (UCODE_DEPTH & (UCODE_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("UCODE_DEPTH must be a power of two and at least 2");
    end

    state_t                   state, state_next;
    logic [ADDR_WIDTH-1:0]    pc, pc_next;
    logic                     advance;
    logic                     frame_done_next;
    logic                     last_batch;
    logic                     end_of_line_unused;
    logic [INSTRUCTION_WIDTH-1:0] instruction;

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        advance         = 1'b0;
        frame_done_next = 1'b0;
        if (new_frame) begin
            state_next = ST_RUN;
            pc_next    = '0;
        end else begin
            case (state)
                ST_IDLE: pc_next = '0;
                ST_RUN: begin
                    if (pc == LAST_PC) begin
                        state_next = ST_DONE;
                    end else begin
                        pc_next = pc + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        advance = 1'b1;
                        pc_next = '0;
                        if (last_batch) begin
                            state_next      = ST_IDLE;
                            frame_done_next = 1'b1;
                        end else begin
                            state_next = ST_RUN;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    pc_next    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            pc         <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            frame_done <= frame_done_next;
        end
    end

    assign result_valid = (state == ST_DONE);
    assign busy         = (state != ST_IDLE);

    pixel_scan_counter #(
        .NUM_PIXELS   (NUM_PIXELS),
        .SCREEN_WIDTH (SCREEN_WIDTH),
        .SCREEN_HEIGHT(SCREEN_HEIGHT)
    ) u_scan (
        .clk         (clk),
        .reset       (reset),
        .restart     (new_frame),
        .advance     (advance),
        .batch_x     (batch_x),
        .batch_y     (batch_y),
        .frame_number(frame_number),
        .end_of_line (end_of_line_unused),
        .last_batch  (last_batch)
    );

    sram_1r1w #(
        .DEPTH(UCODE_DEPTH),
        .WIDTH(INSTRUCTION_WIDTH)
    ) u_ucode (
        .clk    (clk),
        .wr_en  (ucode_wr_en),
        .wr_addr(ucode_wr_addr),
        .wr_data(ucode_wr_data),
        .rd_addr(pc),
        .rd_data(instruction)
    );

    for (genvar i = 0; i < NUM_PIXELS; i++) begin : g_lane
        logic [31:0] lane_x;
        assign lane_x = batch_x + 32'(i);
        pixel_alu #(
            .INSTRUCTION_WIDTH(INSTRUCTION_WIDTH),
            .PIXEL_WIDTH      (PIXEL_WIDTH)
        ) u_alu (
            .clk        (clk),
            .reset      (reset),
            .instruction(instruction),
            .x          (lane_x),
            .y          (batch_y),
            .f          (frame_number),
            .result     (result[lane_lsb(i, PIXEL_WIDTH) +: PIXEL_WIDTH])
        );
    end

endmodule

// File: tb/tb_pixel_processor_array.sv
// tb/tb_pixel_processor_array.sv - self-checking bench for pixel_processor_array
module tb_pixel_processor_array;

    localparam int NP  = 8;
    localparam int SW  = 32;
    localparam int SH  = 480;
    localparam int UD  = 16;
    localparam int IW  = 49;
    localparam int PW  = 12;
    localparam int AW  = $clog2(UD);
    localparam int BPL = SW / NP;
    localparam int NB  = BPL * SH;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              new_frame = 1'b0;
    logic              ucode_wr_en = 1'b0;
    logic [AW-1:0]     ucode_wr_addr = '0;
    logic [IW-1:0]     ucode_wr_data = '0;
    logic [NP*PW-1:0]  result;
    logic              result_valid;
    logic              result_ready = 1'b0;
    logic [31:0]       batch_x;
    logic [31:0]       batch_y;
    logic [31:0]       frame_number;
    logic              frame_done;
    logic              busy;

    always #5 clk = ~clk;

    pixel_processor_array #(
        .NUM_PIXELS       (NP),
        .SCREEN_WIDTH     (SW),
        .SCREEN_HEIGHT    (SH),
        .UCODE_DEPTH      (UD),
        .INSTRUCTION_WIDTH(IW),
        .PIXEL_WIDTH      (PW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .new_frame    (new_frame),
        .ucode_wr_en  (ucode_wr_en),
        .ucode_wr_addr(ucode_wr_addr),
        .ucode_wr_data(ucode_wr_data),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .batch_x      (batch_x),
        .batch_y      (batch_y),
        .frame_number (frame_number),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: microcode image, and a batch-level view of the frame.
    logic [IW-1:0] uc [UD];
    bit            m_active = 1'b0;
    bit            m_done = 1'b0;
    int            m_idx = 0;
    int            m_age = 0;
    logic [31:0]   m_f = '0;
    int            cyc = 0;
    bit            chk_en = 1'b0;

    // Lane value = microcode slots 0..UD-1 applied in order to one pixel.
    function automatic logic [PW-1:0] lane_expect(input int unsigned x, input int unsigned y,
                                                  input int unsigned f);
        int unsigned acc;
        int unsigned op;
        int unsigned imm;
        acc = 0;
        for (int k = 0; k < UD; k++) begin
            op  = 32'(uc[k][2:0]);
            imm = 32'(uc[k][14:3]);
            case (op)
                1: acc = imm;
                2: acc = acc + imm;
                3: acc = acc + x;
                4: acc = acc + y;
                5: acc = acc + f;
                6: acc = acc ^ imm;
                7: acc = acc * 2;
                default: acc = acc;
            endcase
            acc = acc % 4096;
        end
        return PW'(acc);
    endfunction

    always @(posedge clk) begin
        bit v;
        v = m_active && (m_age >= UD);
        cyc++;
        m_done = 1'b0;
        if (reset) begin
            m_active = 1'b0;
            m_idx    = 0;
            m_age    = 0;
            m_f      = '0;
        end else if (new_frame) begin
            m_f      = m_f + 32'd1;
            m_idx    = 0;
            m_age    = 0;
            m_active = 1'b1;
        end else if (m_active) begin
            if (v && result_ready) begin
                if (m_idx == NB - 1) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end else begin
                    m_idx = m_idx + 1;
                    m_age = 0;
                end
            end else if (m_age < UD) begin
                m_age = m_age + 1;
            end
        end
    end

    always @(negedge clk) begin
        bit          mv;
        logic [PW-1:0] got;
        if (chk_en) begin
            mv = m_active && (m_age >= UD);
            check("result_valid", result_valid, mv);
            check("busy", busy, m_active);
            check("frame_done", frame_done, m_done);
            check("frame_number", frame_number, m_f);
            check("batch_x", batch_x, (m_idx % BPL) * NP);
            check("batch_y", batch_y, m_idx / BPL);
            if (mv) begin
                for (int i = 0; i < NP; i++) begin
                    got = result[i*PW +: PW];
                    check($sformatf("lane%0d", i), got,
                          lane_expect((m_idx % BPL) * NP + i, m_idx / BPL, m_f));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IW-1:0] make_instr(input int op, input int imm);
        logic [IW-1:0] w;
        w = IW'({$urandom, $urandom});
        w[2:0]  = 3'(op);
        w[14:3] = 12'(imm);
        return w;
    endfunction

    task automatic write_uc(input int a, input logic [IW-1:0] d);
        ucode_wr_en   = 1'b1;
        ucode_wr_addr = AW'(a);
        ucode_wr_data = d;
        uc[a]         = d;
        tick();
        ucode_wr_en   = 1'b0;
    endtask

    task automatic load_random_ucode();
        write_uc(0, make_instr(1, $urandom_range(4095)));
        for (int k = 1; k < UD - 1; k++) begin
            write_uc(k, make_instr($urandom_range(7), $urandom_range(4095)));
        end
        write_uc(UD - 1, make_instr($urandom_range(1), $urandom_range(4095)));
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (result_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
    endtask

    initial begin
        bit ok;
        bit done_seen;
        int t0;
        int th;
        int fd_count;

        repeat (3) tick();
        chk_en = 1'b1;
        reset  = 1'b0;

        // Idle after reset
        repeat (100) tick();
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_valid", result_valid, 0);
        check("idle_frame", frame_number, 0);

        // Hand microcode: LOAD 5, ADD_X, ADD_Y, ADD_F, then NOPs
        tick();
        write_uc(0, make_instr(1, 5));
        write_uc(1, make_instr(3, 0));
        write_uc(2, make_instr(4, 0));
        write_uc(3, make_instr(5, 0));
        for (int k = 4; k < UD; k++) write_uc(k, make_instr(0, $urandom_range(4095)));
        check("model_pin", lane_expect(3, 0, 1), 9);

        // First batch latency and hold with ready low
        new_frame = 1'b1;
        t0 = cyc;
        tick();
        new_frame = 1'b0;
        wait_valid(40, ok);
        check("first_valid_seen", ok, 1);
        check("first_latency", cyc - t0, 17);
        check("first_lane3", result[3*PW +: PW], 9);
        check("first_frame", frame_number, 1);
        repeat (10) begin
            @(negedge clk);
            check("hold_valid", result_valid, 1);
            check("hold_lane3", result[3*PW +: PW], 9);
            check("hold_x", batch_x, 0);
        end

        // Second batch after handshake
        th = cyc;
        handshake();
        wait_valid(40, ok);
        check("second_valid_seen", ok, 1);
        check("second_latency", cyc - th, 17);
        check("second_x", batch_x, 8);
        check("second_lane3", result[3*PW +: PW], 17);

        // Restart in the middle of a batch
        handshake();
        repeat (5) tick();
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
        @(negedge clk);
        check("restart_frame", frame_number, 2);
        check("restart_x", batch_x, 0);
        check("restart_valid", result_valid, 0);

        // Restart coinciding with a handshake
        wait_valid(40, ok);
        check("coincide_valid_seen", ok, 1);
        result_ready = 1'b1;
        new_frame    = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        new_frame    = 1'b0;
        @(negedge clk);
        check("coincide_done", frame_done, 0);
        check("coincide_frame", frame_number, 3);
        check("coincide_x", batch_x, 0);
        check("coincide_busy", busy, 1);

        // Reset while DONE
        wait_valid(40, ok);
        check("reset_valid_seen", ok, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_valid", result_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_frame", frame_number, 0);
        check("reset_y", batch_y, 0);

        // Full frame, random microcode, random ready
        tick();
        load_random_ucode();
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
        fd_count  = 0;
        done_seen = 1'b0;
        for (int c = 0; c < 40000; c++) begin
            @(negedge clk);
            if (frame_done) begin
                fd_count++;
                done_seen = 1'b1;
                check("end_busy", busy, 0);
                check("end_x", batch_x, SW - NP);
                check("end_y", batch_y, SH - 1);
                check("end_frame", frame_number, 1);
                break;
            end
            result_ready = ($urandom_range(3) != 0);
        end
        check("frame_completed", done_seen, 1);
        repeat (20) begin
            @(negedge clk);
            if (frame_done) fd_count++;
            result_ready = ($urandom_range(1) != 0);
        end
        check("frame_done_pulses", fd_count, 1);
        check("after_end_valid", result_valid, 0);

        // Second random program, partial frame
        result_ready = 1'b0;
        tick();
        load_random_ucode();
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
        repeat (600) begin
            @(negedge clk);
            result_ready = ($urandom_range(3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
